// File: rtl/bp_uce_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module   : bp_uce_mem_arbiter
// Brief    : Merges the I$ and D$ UCE BedRock stream mem buses onto a single
//            downstream mem bus. Commands are arbitrated round-robin and
//            stay locked to one requester until the last data beat.
//            Responses are steered back by the lce_id field of the header.
//            A per-port outstanding-command limit bounds in-flight traffic.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports:
//   clk_i, reset_i (async, active-low)
//   lce_id_i[1:0]                  static LCE ids ([0]=I$, [1]=D$)
//   req_cmd_*  (per UCE, in)       command header/data stream from UCEs
//   req_resp_* (per UCE, out)      response header/data stream to UCEs
//   mem_cmd_*  (out)               shared downstream command stream
//   mem_resp_* (in)                shared downstream response stream
//   error_o                        sticky: response with unmatched lce_id
//
// Optional build macro:
//   BP_UCE_ARB_FIXED_PRIO_EN - D$ (port 1) always wins a simultaneous
//   request; the round-robin pointer is removed.
//
// The processor-config derived widths are exposed as plain parameters;
// lce_id_lsb_p locates the lce_id field inside the mem header.
//============================================================================
module bp_uce_mem_arbiter #(
    parameter int paddr_width_p       = 40,
    parameter int lce_id_width_p      = 4,
    parameter int uce_fill_width_p    = 64,
    parameter int lce_id_lsb_p        = paddr_width_p,
    parameter int mem_header_width_lp = paddr_width_p + lce_id_width_p + 16,
    parameter int max_outstanding_p   = 8
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [1:0][lce_id_width_p-1:0]      lce_id_i,

    input  logic [1:0][mem_header_width_lp-1:0] req_cmd_header_i,
    input  logic [1:0]                          req_cmd_header_v_i,
    output logic [1:0]                          req_cmd_header_ready_and_o,
    input  logic [1:0]                          req_cmd_has_data_i,
    input  logic [1:0][uce_fill_width_p-1:0]    req_cmd_data_i,
    input  logic [1:0]                          req_cmd_data_v_i,
    output logic [1:0]                          req_cmd_data_ready_and_o,
    input  logic [1:0]                          req_cmd_last_i,

    output logic [1:0][mem_header_width_lp-1:0] req_resp_header_o,
    output logic [1:0]                          req_resp_header_v_o,
    input  logic [1:0]                          req_resp_header_ready_and_i,
    output logic [1:0]                          req_resp_has_data_o,
    output logic [1:0][uce_fill_width_p-1:0]    req_resp_data_o,
    output logic [1:0]                          req_resp_data_v_o,
    input  logic [1:0]                          req_resp_data_ready_and_i,
    output logic [1:0]                          req_resp_last_o,

    output logic [mem_header_width_lp-1:0]      mem_cmd_header_o,
    output logic                                mem_cmd_header_v_o,
    input  logic                                mem_cmd_header_ready_and_i,
    output logic                                mem_cmd_has_data_o,
    output logic [uce_fill_width_p-1:0]         mem_cmd_data_o,
    output logic                                mem_cmd_data_v_o,
    input  logic                                mem_cmd_data_ready_and_i,
    output logic                                mem_cmd_last_o,

    input  logic [mem_header_width_lp-1:0]      mem_resp_header_i,
    input  logic                                mem_resp_header_v_i,
    output logic                                mem_resp_header_ready_and_o,
    input  logic                                mem_resp_has_data_i,
    input  logic [uce_fill_width_p-1:0]         mem_resp_data_i,
    input  logic                                mem_resp_data_v_i,
    output logic                                mem_resp_data_ready_and_o,
    input  logic                                mem_resp_last_i,

    output logic                                error_o
);

    localparam int                c_cnt_w   = $clog2(max_outstanding_p + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(max_outstanding_p);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_data  = 2'd1,
        e_drain = 2'd2
    } state_e;

    state_e                   r_cmd_state;
    state_e                   r_rsp_state;
    logic                     r_grant;
    logic                     r_dest;
    logic                     r_error;
    logic [1:0][c_cnt_w-1:0]  r_cnt;

    logic [1:0]               w_elig;
    logic                     w_any;
    logic                     w_grant;
    logic                     w_cmd_hdr_hs;
    logic                     w_cmd_data_hs;
    logic [lce_id_width_p-1:0] w_rsp_lce;
    logic                     w_rsp_hit0;
    logic                     w_rsp_hit1;
    logic                     w_rsp_match;
    logic                     w_rsp_dest;
    logic                     w_rsp_hdr_hs;
    logic                     w_rsp_data_hs;
    logic [1:0]               w_inc;
    logic [1:0]               w_dec;

    //------------------------------------------------------------------
    // Command arbitration
    //------------------------------------------------------------------
    assign w_elig[0] = req_cmd_header_v_i[0] & (r_cnt[0] < c_cnt_max);
    assign w_elig[1] = req_cmd_header_v_i[1] & (r_cnt[1] < c_cnt_max);
    assign w_any     = |w_elig;

`ifdef BP_UCE_ARB_FIXED_PRIO_EN
    // D$ wins whenever it is eligible
    assign w_grant = w_elig[1];
`else
    logic r_rr;

    // Pointer only matters on a tie; otherwise the lone eligible port wins
    assign w_grant = (&w_elig) ? r_rr : w_elig[1];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rr <= 1'b0;
        end else if (w_cmd_hdr_hs) begin
            r_rr <= ~w_grant;
        end
    end
`endif

    // Header side only exists in idle; data side only while locked in e_data
    assign mem_cmd_header_o   = req_cmd_header_i[w_grant];
    assign mem_cmd_has_data_o = req_cmd_has_data_i[w_grant];
    assign mem_cmd_header_v_o = reset_i & (r_cmd_state == e_idle) & w_any;
    assign mem_cmd_data_o     = req_cmd_data_i[r_grant];
    assign mem_cmd_last_o     = req_cmd_last_i[r_grant];
    assign mem_cmd_data_v_o   = reset_i & (r_cmd_state == e_data) & req_cmd_data_v_i[r_grant];

    assign w_cmd_hdr_hs  = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
    assign w_cmd_data_hs = mem_cmd_data_v_o & mem_cmd_data_ready_and_i;

    always_comb begin
        req_cmd_header_ready_and_o = '0;
        req_cmd_data_ready_and_o   = '0;
        if (reset_i) begin
            if ((r_cmd_state == e_idle) && w_any) begin
                req_cmd_header_ready_and_o[w_grant] = mem_cmd_header_ready_and_i;
            end
            if (r_cmd_state == e_data) begin
                req_cmd_data_ready_and_o[r_grant] = mem_cmd_data_ready_and_i;
            end
        end
    end

    //------------------------------------------------------------------
    // Response steering
    //------------------------------------------------------------------
    assign w_rsp_lce   = mem_resp_header_i[lce_id_lsb_p +: lce_id_width_p];
    assign w_rsp_hit0  = (w_rsp_lce == lce_id_i[0]);
    assign w_rsp_hit1  = (w_rsp_lce == lce_id_i[1]);
    assign w_rsp_match = w_rsp_hit0 | w_rsp_hit1;
    assign w_rsp_dest  = w_rsp_hit1;

    // Payloads are broadcast; only the valids select the destination
    assign req_resp_header_o   = {2{mem_resp_header_i}};
    assign req_resp_has_data_o = {2{mem_resp_has_data_i}};
    assign req_resp_data_o     = {2{mem_resp_data_i}};
    assign req_resp_last_o     = {2{mem_resp_last_i}};

    always_comb begin
        req_resp_header_v_o         = '0;
        req_resp_data_v_o           = '0;
        mem_resp_header_ready_and_o = 1'b0;
        mem_resp_data_ready_and_o   = 1'b0;
        if (reset_i) begin
            case (r_rsp_state)
                e_idle: begin
                    if (w_rsp_match) begin
                        req_resp_header_v_o[w_rsp_dest] = mem_resp_header_v_i;
                        mem_resp_header_ready_and_o     = req_resp_header_ready_and_i[w_rsp_dest];
                    end else begin
                        // Orphan headers are swallowed so the bus cannot wedge
                        mem_resp_header_ready_and_o = 1'b1;
                    end
                end
                e_data: begin
                    req_resp_data_v_o[r_dest] = mem_resp_data_v_i;
                    mem_resp_data_ready_and_o = req_resp_data_ready_and_i[r_dest];
                end
                e_drain: begin
                    mem_resp_data_ready_and_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_rsp_hdr_hs  = mem_resp_header_v_i & mem_resp_header_ready_and_o;
    assign w_rsp_data_hs = mem_resp_data_v_i & mem_resp_data_ready_and_o;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_cmd_hdr_hs)                w_inc[w_grant]    = 1'b1;
        if (w_rsp_hdr_hs && w_rsp_match) w_dec[w_rsp_dest] = 1'b1;
    end

    //------------------------------------------------------------------
    // Cmd FSM, resp FSM, counters and error flag
    //------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cmd_state <= e_idle;
            r_rsp_state <= e_idle;
            r_grant     <= 1'b0;
            r_dest      <= 1'b0;
            r_error     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_cmd_state)
                e_idle: begin
                    if (w_cmd_hdr_hs) begin
                        r_grant <= w_grant;
                        if (req_cmd_has_data_i[w_grant]) r_cmd_state <= e_data;
                    end
                end
                e_data: begin
                    if (w_cmd_data_hs && mem_cmd_last_o) r_cmd_state <= e_idle;
                end
                default: r_cmd_state <= e_idle;
            endcase

            case (r_rsp_state)
                e_idle: begin
                    if (w_rsp_hdr_hs) begin
                        if (!w_rsp_match) r_error <= 1'b1;
                        if (mem_resp_has_data_i) begin
                            r_dest      <= w_rsp_dest;
                            r_rsp_state <= w_rsp_match ? e_data : e_drain;
                        end
                    end
                end
                e_data, e_drain: begin
                    if (w_rsp_data_hs && mem_resp_last_i) r_rsp_state <= e_idle;
                end
                default: r_rsp_state <= e_idle;
            endcase

            // Saturating counters; simultaneous inc/dec cancel
            for (int p = 0; p < 2; p++) begin
                if (w_inc[p] && !w_dec[p] && (r_cnt[p] != c_cnt_max)) begin
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                end else if (w_dec[p] && !w_inc[p] && (r_cnt[p] != '0)) begin
                    r_cnt[p] <= r_cnt[p] - 1'b1;
                end
            end
        end
    end

    assign error_o = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bp_uce_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_bp_uce_mem_arbiter
// Brief    : Scoreboard bench for bp_uce_mem_arbiter. Stimulus pushes the
//            expected downstream command / upstream response traffic into
//            queues; a negedge monitor pops and compares on each handshake.
// Revision : 1.0 - initial release
//============================================================================
module tb_bp_uce_mem_arbiter;

    localparam int PA = 8;
    localparam int LW = 4;
    localparam int FW = 16;
    localparam int HW = PA + LW + 8;
    localparam int MO = 8;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [1:0][LW-1:0]  lce_id_i;

    logic [1:0][HW-1:0]  req_cmd_header_i;
    logic [1:0]          req_cmd_header_v_i;
    logic [1:0]          req_cmd_header_ready_and_o;
    logic [1:0]          req_cmd_has_data_i;
    logic [1:0][FW-1:0]  req_cmd_data_i;
    logic [1:0]          req_cmd_data_v_i;
    logic [1:0]          req_cmd_data_ready_and_o;
    logic [1:0]          req_cmd_last_i;

    logic [1:0][HW-1:0]  req_resp_header_o;
    logic [1:0]          req_resp_header_v_o;
    logic [1:0]          req_resp_header_ready_and_i;
    logic [1:0]          req_resp_has_data_o;
    logic [1:0][FW-1:0]  req_resp_data_o;
    logic [1:0]          req_resp_data_v_o;
    logic [1:0]          req_resp_data_ready_and_i;
    logic [1:0]          req_resp_last_o;

    logic [HW-1:0]       mem_cmd_header_o;
    logic                mem_cmd_header_v_o;
    logic                mem_cmd_header_ready_and_i;
    logic                mem_cmd_has_data_o;
    logic [FW-1:0]       mem_cmd_data_o;
    logic                mem_cmd_data_v_o;
    logic                mem_cmd_data_ready_and_i;
    logic                mem_cmd_last_o;

    logic [HW-1:0]       mem_resp_header_i;
    logic                mem_resp_header_v_i;
    logic                mem_resp_header_ready_and_o;
    logic                mem_resp_has_data_i;
    logic [FW-1:0]       mem_resp_data_i;
    logic                mem_resp_data_v_i;
    logic                mem_resp_data_ready_and_o;
    logic                mem_resp_last_i;

    logic                error_o;

    bp_uce_mem_arbiter #(
        .paddr_width_p       (PA),
        .lce_id_width_p      (LW),
        .uce_fill_width_p    (FW),
        .lce_id_lsb_p        (8),
        .mem_header_width_lp (HW),
        .max_outstanding_p   (MO)
    ) dut (
        .clk_i                       (clk),
        .reset_i                     (reset_i),
        .lce_id_i                    (lce_id_i),
        .req_cmd_header_i            (req_cmd_header_i),
        .req_cmd_header_v_i          (req_cmd_header_v_i),
        .req_cmd_header_ready_and_o  (req_cmd_header_ready_and_o),
        .req_cmd_has_data_i          (req_cmd_has_data_i),
        .req_cmd_data_i              (req_cmd_data_i),
        .req_cmd_data_v_i            (req_cmd_data_v_i),
        .req_cmd_data_ready_and_o    (req_cmd_data_ready_and_o),
        .req_cmd_last_i              (req_cmd_last_i),
        .req_resp_header_o           (req_resp_header_o),
        .req_resp_header_v_o         (req_resp_header_v_o),
        .req_resp_header_ready_and_i (req_resp_header_ready_and_i),
        .req_resp_has_data_o         (req_resp_has_data_o),
        .req_resp_data_o             (req_resp_data_o),
        .req_resp_data_v_o           (req_resp_data_v_o),
        .req_resp_data_ready_and_i   (req_resp_data_ready_and_i),
        .req_resp_last_o             (req_resp_last_o),
        .mem_cmd_header_o            (mem_cmd_header_o),
        .mem_cmd_header_v_o          (mem_cmd_header_v_o),
        .mem_cmd_header_ready_and_i  (mem_cmd_header_ready_and_i),
        .mem_cmd_has_data_o          (mem_cmd_has_data_o),
        .mem_cmd_data_o              (mem_cmd_data_o),
        .mem_cmd_data_v_o            (mem_cmd_data_v_o),
        .mem_cmd_data_ready_and_i    (mem_cmd_data_ready_and_i),
        .mem_cmd_last_o              (mem_cmd_last_o),
        .mem_resp_header_i           (mem_resp_header_i),
        .mem_resp_header_v_i         (mem_resp_header_v_i),
        .mem_resp_header_ready_and_o (mem_resp_header_ready_and_o),
        .mem_resp_has_data_i         (mem_resp_has_data_i),
        .mem_resp_data_i             (mem_resp_data_i),
        .mem_resp_data_v_i           (mem_resp_data_v_i),
        .mem_resp_data_ready_and_o   (mem_resp_data_ready_and_o),
        .mem_resp_last_i             (mem_resp_last_i),
        .error_o                     (error_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues
    logic [HW:0]   q_cmd_hdr[$];   // {port, header}
    logic [FW:0]   q_cmd_dat[$];   // {last, data}
    logic [HW:0]   q_rsp_hdr[$];   // {port, header}
    logic [FW+1:0] q_rsp_dat[$];   // {port, last, data}
    int            v_seen[2];

    logic [HW:0]   m_hdr;
    logic [FW:0]   m_cdat;
    logic [FW+1:0] m_rdat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected nothing", nm, act);
    endtask

    function automatic logic [HW-1:0] mkh(input logic [7:0] a, input logic [3:0] l, input logic [7:0] t);
        return {a, l, t};
    endfunction

    //------------------------------------------------------------------
    // Monitor
    //------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset_i) begin
            if (mem_cmd_header_v_o && mem_cmd_header_ready_and_i) begin
                if (q_cmd_hdr.size() == 0) extra("cmd_hdr_extra", {63'(mem_cmd_header_o)});
                else begin
                    m_hdr = q_cmd_hdr.pop_front();
                    chk("cmd_hdr", {req_cmd_header_ready_and_o[1], mem_cmd_header_o}, m_hdr);
                end
            end
            if (mem_cmd_data_v_o && mem_cmd_data_ready_and_i) begin
                if (q_cmd_dat.size() == 0) extra("cmd_dat_extra", {63'(mem_cmd_data_o)});
                else begin
                    m_cdat = q_cmd_dat.pop_front();
                    chk("cmd_dat", {mem_cmd_last_o, mem_cmd_data_o}, m_cdat);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (req_resp_header_v_o[p] || req_resp_data_v_o[p]) v_seen[p]++;
                if (req_resp_header_v_o[p] && req_resp_header_ready_and_i[p]) begin
                    if (q_rsp_hdr.size() == 0) extra("rsp_hdr_extra", {63'(req_resp_header_o[p])});
                    else begin
                        m_hdr = q_rsp_hdr.pop_front();
                        chk("rsp_hdr", {1'(p), req_resp_header_o[p]}, m_hdr);
                    end
                end
                if (req_resp_data_v_o[p] && req_resp_data_ready_and_i[p]) begin
                    if (q_rsp_dat.size() == 0) extra("rsp_dat_extra", {63'(req_resp_data_o[p])});
                    else begin
                        m_rdat = q_rsp_dat.pop_front();
                        chk("rsp_dat", {1'(p), req_resp_last_o[p], req_resp_data_o[p]}, m_rdat);
                    end
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Stimulus helpers
    //------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_cmd_header_i            = '0;
        req_cmd_header_v_i          = '0;
        req_cmd_has_data_i          = '0;
        req_cmd_data_i              = '0;
        req_cmd_data_v_i            = '0;
        req_cmd_last_i              = '0;
        req_resp_header_ready_and_i = 2'b11;
        req_resp_data_ready_and_i   = 2'b11;
        mem_cmd_header_ready_and_i  = 1'b1;
        mem_cmd_data_ready_and_i    = 1'b1;
        mem_resp_header_i           = '0;
        mem_resp_header_v_i         = 1'b0;
        mem_resp_has_data_i         = 1'b0;
        mem_resp_data_i             = '0;
        mem_resp_data_v_i           = 1'b0;
        mem_resp_last_i             = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        clear_inputs();
        repeat (2) tick();
        reset_i = 1'b1;
        tick();
    endtask

    task automatic send_cmd_hdr(input int p, input logic [HW-1:0] h, input logic hd);
        req_cmd_header_i[p]   = h;
        req_cmd_has_data_i[p] = hd;
        req_cmd_header_v_i[p] = 1'b1;
        q_cmd_hdr.push_back({1'(p), h});
    endtask

    task automatic wait_cmd_hdrs(input logic [1:0] mask);
        logic [1:0] pend;
        logic [1:0] hs;
        int         n;
        pend = mask;
        n    = 0;
        while (pend != 2'b00 && n < 40) begin
            @(negedge clk);
            hs = req_cmd_header_v_i & req_cmd_header_ready_and_o & pend;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) begin
                    req_cmd_header_v_i[p] = 1'b0;
                    pend[p] = 1'b0;
                end
            end
            n++;
        end
        if (pend != 2'b00) begin
            total++;
            bad++;
            $display("FAIL cmd_hdr_timeout: pending %b expected 00", pend);
            req_cmd_header_v_i = '0;
        end
    endtask

    task automatic wait_rsp_hdr();
        logic hs;
        int   n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 40) begin
            @(negedge clk);
            hs = mem_resp_header_v_i & mem_resp_header_ready_and_o;
            @(posedge clk);
            #1;
            n++;
        end
        mem_resp_header_v_i = 1'b0;
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL rsp_hdr_timeout: got no handshake expected one");
        end
    endtask

    task automatic send_rsp_beats(input int nb, input logic [FW-1:0] base, input logic toggle_d);
        int   b;
        int   cyc;
        logic hs;
        b   = 0;
        cyc = 0;
        while (b < nb && cyc < 40) begin
            mem_resp_data_v_i = 1'b1;
            mem_resp_data_i   = base + FW'(b);
            mem_resp_last_i   = (b == nb - 1);
            if (toggle_d) req_resp_data_ready_and_i[1] = (cyc % 2 == 1);
            @(negedge clk);
            hs = mem_resp_data_v_i & mem_resp_data_ready_and_o;
            @(posedge clk);
            #1;
            if (hs) b++;
            cyc++;
        end
        mem_resp_data_v_i         = 1'b0;
        mem_resp_last_i           = 1'b0;
        req_resp_data_ready_and_i = 2'b11;
        if (b < nb) begin
            total++;
            bad++;
            $display("FAIL rsp_dat_timeout: got %0d beats expected %0d", b, nb);
        end
    endtask

    //------------------------------------------------------------------
    // Directed sequence
    //------------------------------------------------------------------
    initial begin
        lce_id_i[0] = 4'h3;
        lce_id_i[1] = 4'h5;
        v_seen[0]   = 0;
        v_seen[1]   = 0;
        reset_i     = 1'b0;
        clear_inputs();

        // Outputs forced quiet during reset even with requests present
        req_cmd_header_v_i  = 2'b11;
        mem_resp_header_v_i = 1'b1;
        mem_resp_header_i   = mkh(8'h00, 4'h3, 8'h00);
        #2;
        chk("rst_cmd_hdr_v", mem_cmd_header_v_o, 0);
        chk("rst_cmd_hdr_rdy", req_cmd_header_ready_and_o, 0);
        chk("rst_rsp_hdr_v", req_resp_header_v_o, 0);
        chk("rst_rsp_hdr_rdy", mem_resp_header_ready_and_o, 0);
        chk("rst_error", error_o, 0);
        do_reset();

        // Round-robin: tie -> I$ then D$; after a lone I$ grant, tie -> D$ first
        send_cmd_hdr(0, mkh(8'h10, 4'h3, 8'h01), 1'b0);
        send_cmd_hdr(1, mkh(8'h11, 4'h5, 8'h02), 1'b0);
        wait_cmd_hdrs(2'b11);
        send_cmd_hdr(0, mkh(8'h12, 4'h3, 8'h03), 1'b0);
        wait_cmd_hdrs(2'b01);
        send_cmd_hdr(1, mkh(8'h13, 4'h5, 8'h04), 1'b0);
        send_cmd_hdr(0, mkh(8'h14, 4'h3, 8'h05), 1'b0);
        wait_cmd_hdrs(2'b11);

        // D$ 4-beat write; I$ header arriving mid-burst stays blocked
        do_reset();
        send_cmd_hdr(1, mkh(8'h20, 4'h5, 8'h21), 1'b1);
        wait_cmd_hdrs(2'b10);
        for (int b = 0; b < 4; b++) q_cmd_dat.push_back({(b == 3), 16'hd000 + 16'(b)});
        for (int b = 0; b < 4; b++) begin
            req_cmd_data_v_i[1] = 1'b1;
            req_cmd_data_i[1]   = 16'hd000 + 16'(b);
            req_cmd_last_i[1]   = (b == 3);
            if (b == 1) send_cmd_hdr(0, mkh(8'h30, 4'h3, 8'h31), 1'b0);
            @(negedge clk);
            chk("d_data_ready", req_cmd_data_ready_and_o[1], 1);
            if (b >= 1) chk("i_hdr_blocked", req_cmd_header_ready_and_o[0], 0);
            tick();
        end
        req_cmd_data_v_i = '0;
        req_cmd_last_i   = '0;
        @(negedge clk);
        chk("i_hdr_after_last", req_cmd_header_ready_and_o[0], 1);
        tick();
        req_cmd_header_v_i[0] = 1'b0;

        // Outstanding limit on I$
        do_reset();
        for (int k = 0; k < MO; k++) begin
            send_cmd_hdr(0, mkh(8'h40 + 8'(k), 4'h3, 8'(k)), 1'b0);
            wait_cmd_hdrs(2'b01);
        end
        send_cmd_hdr(0, mkh(8'h50, 4'h3, 8'h99), 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("i_hdr_limit", req_cmd_header_ready_and_o[0], 0);
            chk("cmd_v_limit", mem_cmd_header_v_o, 0);
            tick();
        end
        mem_resp_header_i   = mkh(8'h40, 4'h3, 8'ha0);
        mem_resp_has_data_i = 1'b0;
        mem_resp_header_v_i = 1'b1;
        q_rsp_hdr.push_back({1'b0, mkh(8'h40, 4'h3, 8'ha0)});
        @(negedge clk);
        chk("rsp_hdr_ready", mem_resp_header_ready_and_o, 1);
        chk("i_hdr_still_blocked", req_cmd_header_ready_and_o[0], 0);
        tick();
        mem_resp_header_v_i = 1'b0;
        @(negedge clk);
        chk("i_hdr_after_rsp", req_cmd_header_ready_and_o[0], 1);
        tick();
        req_cmd_header_v_i[0] = 1'b0;

        // Unmatched response with data: drained, sticky error, count unchanged
        v_seen[0] = 0;
        v_seen[1] = 0;
        req_resp_header_ready_and_i = 2'b00;
        req_resp_data_ready_and_i   = 2'b00;
        chk("err_before", error_o, 0);
        mem_resp_header_i   = mkh(8'h60, 4'h9, 8'hb0);
        mem_resp_has_data_i = 1'b1;
        mem_resp_header_v_i = 1'b1;
        @(negedge clk);
        chk("unm_hdr_ready", mem_resp_header_ready_and_o, 1);
        tick();
        mem_resp_header_v_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_data_v_i = 1'b1;
            mem_resp_data_i   = 16'hbee0 + 16'(b);
            mem_resp_last_i   = (b == 1);
            @(negedge clk);
            chk("drain_ready", mem_resp_data_ready_and_o, 1);
            tick();
        end
        mem_resp_data_v_i = 1'b0;
        mem_resp_last_i   = 1'b0;
        chk("err_set", error_o, 1);
        repeat (3) tick();
        chk("err_sticky", error_o, 1);
        chk("unm_no_valid", v_seen[0] + v_seen[1], 0);
        req_cmd_header_i[0]   = mkh(8'h51, 4'h3, 8'h9a);
        req_cmd_header_v_i[0] = 1'b1;
        @(negedge clk);
        chk("i_cnt_unchanged", req_cmd_header_ready_and_o[0], 0);
        tick();
        req_cmd_header_v_i[0]       = 1'b0;
        req_resp_header_ready_and_i = 2'b11;
        req_resp_data_ready_and_i   = 2'b11;
        // Resp FSM must be back in idle after the drain
        mem_resp_header_i   = mkh(8'h41, 4'h3, 8'ha1);
        mem_resp_has_data_i = 1'b0;
        mem_resp_header_v_i = 1'b1;
        q_rsp_hdr.push_back({1'b0, mkh(8'h41, 4'h3, 8'ha1)});
        wait_rsp_hdr();

        // D$ response with 2 beats, D$ data ready toggling
        do_reset();
        chk("err_cleared", error_o, 0);
        v_seen[0] = 0;
        mem_resp_header_i   = mkh(8'h70, 4'h5, 8'hc0);
        mem_resp_has_data_i = 1'b1;
        mem_resp_header_v_i = 1'b1;
        q_rsp_hdr.push_back({1'b1, mkh(8'h70, 4'h5, 8'hc0)});
        wait_rsp_hdr();
        q_rsp_dat.push_back({1'b1, 1'b0, 16'he000});
        q_rsp_dat.push_back({1'b1, 1'b1, 16'he001});
        send_rsp_beats(2, 16'he000, 1'b1);
        chk("i_rsp_quiet", v_seen[0], 0);

        // Reset mid D$ burst
        do_reset();
        send_cmd_hdr(1, mkh(8'h80, 4'h5, 8'hd0), 1'b1);
        wait_cmd_hdrs(2'b10);
        q_cmd_dat.push_back({1'b0, 16'hf000});
        q_cmd_dat.push_back({1'b0, 16'hf001});
        for (int b = 0; b < 2; b++) begin
            req_cmd_data_v_i[1] = 1'b1;
            req_cmd_data_i[1]   = 16'hf000 + 16'(b);
            req_cmd_last_i[1]   = 1'b0;
            tick();
        end
        req_cmd_data_i[1]     = 16'hf002;
        req_cmd_header_i[0]   = mkh(8'h90, 4'h3, 8'he0);
        req_cmd_header_v_i[0] = 1'b1;
        #2;
        reset_i = 1'b0;
        #1;
        chk("rst_mid_data_v", mem_cmd_data_v_o, 0);
        chk("rst_mid_data_rdy", req_cmd_data_ready_and_o, 0);
        chk("rst_mid_hdr_v", mem_cmd_header_v_o, 0);
        chk("rst_mid_hdr_rdy", req_cmd_header_ready_and_o, 0);
        tick();
        req_cmd_data_v_i = '0;
        send_cmd_hdr(0, mkh(8'h90, 4'h3, 8'he0), 1'b0);
        send_cmd_hdr(1, mkh(8'h91, 4'h5, 8'he1), 1'b0);
        reset_i = 1'b1;
        wait_cmd_hdrs(2'b11);
        chk("err_after_rst", error_o, 0);

        repeat (3) tick();
        chk("q_cmd_hdr_empty", q_cmd_hdr.size(), 0);
        chk("q_cmd_dat_empty", q_cmd_dat.size(), 0);
        chk("q_rsp_hdr_empty", q_rsp_hdr.size(), 0);
        chk("q_rsp_dat_empty", q_rsp_dat.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_uce_mem_arbiter.md
Name: bp_uce_mem_arbiter

Overview:
Merges the two BedRock stream mem buses produced by the I$ and D$ UCEs onto one shared downstream mem bus. Commands use round-robin arbitration and stay locked to one requester until the message's last data beat. Responses are steered back to the owning UCE by the lce_id field in the response header. A per-port outstanding-transaction limit bounds in-flight traffic. The block sits between the unicore-lite cache engines and the single memory/IO port of the tile.

Parameters:
bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, lce_id_width_p, uce_fill_width_p, mem_header_width_lp.
max_outstanding_p, 8, maximum unanswered commands per requester port (>=1).

Ports:
clk_i  in  1  clock; all state on posedge
reset_i  in  1  asynchronous, active-low reset
lce_id_i  in  2 x lce_id_width_p  [0]=I$ LCE id, [1]=D$ LCE id; static after reset
req_cmd_header_i / _v_i / _ready_and_o  in/in/out  2 x mem_header_width_lp / 2 / 2  per-UCE cmd header channel
req_cmd_has_data_i  in  2  header is followed by data beats
req_cmd_data_i / _v_i / _ready_and_o / _last_i  in/in/out/in  2 x uce_fill_width_p / 2 / 2 / 2  per-UCE cmd data channel
req_resp_header_o / _v_o / _ready_and_i, req_resp_has_data_o, req_resp_data_o / _v_o / _ready_and_i / _last_o  mirror of the above, response direction to each UCE
mem_cmd_header_o / _v_o / _ready_and_i, mem_cmd_has_data_o, mem_cmd_data_o / _v_o / _ready_and_i / _last_o  single downstream cmd bus
mem_resp_header_i / _v_i / _ready_and_o, mem_resp_has_data_i, mem_resp_data_i / _v_i / _ready_and_o / _last_i  single downstream resp bus
error_o  out  1  sticky: response with unmatched lce_id

Behaviour:
- Reset (async, reset_i=0): cmd FSM and resp FSM to e_idle; rr pointer=0 (I$ preferred); outstanding counters=0; error_o=0. All *_v_o and *_ready_and_o are 0 while in reset. A partial message in flight at reset is abandoned with no replay.
- Eligibility: port p may be granted only if req_cmd_header_v_i[p] and cnt[p] < max_outstanding_p.
- Cmd FSM e_idle:
  - grant = eligible port; if both are eligible, the port at rr pointer wins. Grant is combinational (zero-latency pass-through).
  - mem_cmd_header_o/_v_o/_has_data_o come from the granted port.
  - req_cmd_header_ready_and_o[grant] = mem_cmd_header_ready_and_i; the loser's ready is 0.
  - On header handshake: rr pointer = ~grant; cnt[grant]++; latch grant_r. If has_data, go to e_data; otherwise stay in e_idle.
  - All cmd data readies are 0 in e_idle.
- Cmd FSM e_data:
  - Data channel passes through from grant_r only; header readies are 0 for both ports.
  - On data handshake with last: return to e_idle. The next grant is allowed the following cycle.
- Resp FSM e_idle:
  - dest = 1 if the header's lce_id == lce_id_i[1]; dest = 0 if it == lce_id_i[0]; otherwise unmatched.
  - Header is forwarded to dest only. mem_resp_header_ready_and_o = req_resp_header_ready_and_i[dest].
  - On handshake: cnt[dest]--. If has_data, latch dest_r and go to e_data.
  - Unmatched: header consumed immediately (ready=1); error_o set; if has_data, go to e_drain.
- Resp FSM e_data: data passes through to dest_r until the last-beat handshake, then e_idle.
- Resp FSM e_drain: data ready=1, data discarded until the last beat, then e_idle. No counter change.
- Counters: an increment and decrement on the same port in the same cycle leaves it unchanged. Counters saturate; they never wrap below 0 or above max_outstanding_p.
- Cmd and resp FSMs are independent and may progress in the same cycle.
- The block holds no data storage; every valid/data path is combinational from source through the locked mux.

Optional Feature:
BP_UCE_ARB_FIXED_PRIO_EN
- Defined: fixed priority, D$ (port 1) always wins when both ports are eligible; rr pointer is removed.
- Undefined: round-robin as specified above.

Test Plan:
- Simultaneous I$ and D$ header-only reads after reset -> I$ granted first, D$ next cycle; the next simultaneous pair grants D$ first.
- D$ write with has_data=1 and 4 beats; I$ header arrives on beat 2 -> I$ header_ready held 0 until D$ last-beat handshake, then I$ granted the following cycle.
- I$ issues 8 reads with no responses (max_outstanding_p=8) -> 9th header not granted; one I$ response returned -> 9th granted the next cycle.
- Response with lce_id=lce_id_i[1], 2 data beats, D$ ready toggling -> beats reach D$ only, in order; the I$ resp port sees no valid.
- Response with lce_id matching neither port, has_data=1, 2 beats -> all beats consumed, error_o=1 and stays 1, counters unchanged.
- reset_i asserted mid D$ data burst -> all valids drop asynchronously; after release the FSMs are idle and an I$ request is granted first.
